// File: rtl/bd_tx_fifo.sv
// Buffered FPGA->BD transmit link: DEPTH-entry FIFO drained one word per cycle while the
// synchronised BD ready is high, with occupancy status and a wrapping sent-word counter.
module bd_tx_fifo #(
    parameter int unsigned NUM_BITS    = 21,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AFULL_LEVEL = 12,
    parameter int unsigned CNT_BITS    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [NUM_BITS-1:0]       in_data,
    output logic                      in_ack,
    output logic                      valid,
    output logic [NUM_BITS-1:0]       data,
    input  logic                      ready,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic [CNT_BITS-1:0]       sent_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ready_s;

    logic [NUM_BITS-1:0]    mem [DEPTH];

    logic [AW-1:0]          wptr_q, wptr_d;
    logic [AW-1:0]          rptr_q, rptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   valid_q, valid_d;
    logic [NUM_BITS-1:0]    data_q, data_d;
    logic [CNT_BITS-1:0]    sent_q, sent_d;

    logic                   full_c;
    logic                   empty_c;
    logic                   write_c;
    logic                   pop_c;

    // BD ready crosses into clk through a plain flop chain; only the last stage is used.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ready};
        end
    end

    assign ready_s = sync_q[SYNC_STAGES-1];

    // Status comes from the registered occupancy, never from pointer comparison.
    assign full_c  = (count_q == CW'(DEPTH));
    assign empty_c = (count_q == '0);

    // Nothing is accepted while reset is held, so a producer never loses a word to reset.
    assign write_c = in_valid & ~full_c & reset;
    assign pop_c   = ready_s & ~empty_c;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        valid_d = 1'b0;
        data_d  = data_q;
        sent_d  = sent_q;

        if (write_c) begin
            wptr_d = wptr_q + AW'(1);
        end

        if (pop_c) begin
            rptr_d  = rptr_q + AW'(1);
            valid_d = 1'b1;
            data_d  = mem[rptr_q];
            sent_d  = sent_q + CNT_BITS'(1);
        end

        case ({write_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sent_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sent_q  <= sent_d;
        end
    end

    // Storage array carries no reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (write_c) begin
            mem[wptr_q] <= in_data;
        end
    end

    assign in_ack      = write_c;
    assign valid       = valid_q;
    assign data        = data_q;
    assign count       = count_q;
    assign full        = full_c;
    assign empty       = empty_c;
    assign almost_full = (count_q >= CW'(AFULL_LEVEL));
    assign sent_count  = sent_q;

endmodule

// File: tb/tb_bd_tx_fifo.sv
// Bench for bd_tx_fifo: queue-based reference model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_bd_tx_fifo;

    localparam int unsigned NB    = 21;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned AFULL = 12;
    localparam int unsigned CNTB  = 32;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic [NB-1:0]   in_data;
    logic            in_ack;
    logic            valid;
    logic [NB-1:0]   data;
    logic            ready;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic            almost_full;
    logic [CNTB-1:0] sent_count;

    bd_tx_fifo #(
        .NUM_BITS(NB), .DEPTH(DEPTH), .SYNC_STAGES(SYNC), .AFULL_LEVEL(AFULL), .CNT_BITS(CNTB)
    ) dut (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ack(in_ack),
        .valid(valid), .data(data), .ready(ready), .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .sent_count(sent_count)
    );

    always #5 clk = ~clk;

    int ncmp  = 0;
    int nfail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of buffered words, ready seen SYNC edges late.
    logic [NB-1:0]   mq[$];
    bit              rdel[$];
    bit              m_valid;
    logic [NB-1:0]   m_data;
    longint unsigned m_sent;
    bit              m_rs, m_ack, m_pop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            rdel.delete();
            repeat (SYNC) rdel.push_back(1'b0);
            m_valid = 1'b0;
            m_data  = '0;
            m_sent  = 0;
        end else begin
            m_rs  = rdel[0];
            m_ack = in_valid && (mq.size() < int'(DEPTH));
            m_pop = m_rs && (mq.size() > 0);
            if (m_pop) begin
                m_valid = 1'b1;
                m_data  = mq.pop_front();
                m_sent++;
            end else begin
                m_valid = 1'b0;
            end
            if (m_ack) mq.push_back(in_data);
            void'(rdel.pop_front());
            rdel.push_back(ready);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ack", 64'(in_ack), 64'(rst_n && in_valid && (mq.size() < int'(DEPTH))));
            chk("valid", 64'(valid), 64'(m_valid));
            chk("data", 64'(data), 64'(m_data));
            chk("count", 64'(count), 64'(mq.size()));
            chk("full", 64'(full), 64'(mq.size() == int'(DEPTH)));
            chk("empty", 64'(empty), 64'(mq.size() == 0));
            chk("almost_full", 64'(almost_full), 64'(mq.size() >= int'(AFULL)));
            chk("sent_count", 64'(sent_count), 64'(CNTB'(m_sent)));
        end
    end

    // One clock edge; returns just after the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic push_words(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            in_data  = NB'(base + i);
            in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
    endtask

    int edges;
    int extra;
    bit seen;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        ready    = 1'b0;
        #1 rst_n = 1'b0;

        // Reset held with producer and BD both active
        in_valid = 1'b1;
        ready    = 1'b1;
        cyc();
        chk_en = 1'b1;
        cyc();
        chk("rst_in_ack", 64'(in_ack), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_sent", 64'(sent_count), 64'd0);
        in_valid = 1'b0;
        ready    = 1'b0;
        rst_n    = 1'b1;
        repeat (3) cyc();

        // Fill with ready low
        for (int i = 1; i <= 16; i++) begin
            in_data  = NB'(i);
            in_valid = 1'b1;
            #1;
            chk("fill_ack", 64'(in_ack), 64'd1);
            cyc();
            chk("fill_count", 64'(count), 64'(i));
            chk("fill_afull", 64'(almost_full), (i >= 12) ? 64'd1 : 64'd0);
        end
        in_data = NB'(17);
        #1;
        chk("full_flag", 64'(full), 64'd1);
        chk("full_no_ack", 64'(in_ack), 64'd0);
        cyc();
        chk("full_count", 64'(count), 64'd16);
        in_valid = 1'b0;

        // Drain: first valid SYNC+1 edges after ready rises
        ready = 1'b1;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 10) begin
            cyc();
            edges++;
            seen = valid;
        end
        chk("drain_latency", 64'(edges), 64'd3);
        for (int i = 1; i <= 16; i++) begin
            chk("drain_valid", 64'(valid), 64'd1);
            chk("drain_data", 64'(data), 64'(i));
            cyc();
        end
        chk("drain_gap_valid", 64'(valid), 64'd0);
        chk("drain_empty", 64'(empty), 64'd1);
        chk("drain_sent", 64'(sent_count), 64'd16);

        // Stream with ready high: one-edge latency, occupancy stays at 1
        for (int i = 0; i < 256; i++) begin
            in_data  = NB'(i);
            in_valid = 1'b1;
            cyc();
            chk("stream_count", 64'(count), 64'd1);
            if (i > 0) begin
                chk("stream_valid", 64'(valid), 64'd1);
                chk("stream_data", 64'(data), 64'(i - 1));
            end
        end
        in_valid = 1'b0;
        cyc();
        chk("stream_last", 64'(data), 64'hFF);
        chk("stream_cnt0", 64'(count), 64'd0);
        cyc();
        chk("stream_idle", 64'(valid), 64'd0);
        chk("stream_sent", 64'(sent_count), 64'd272);

        // Full with simultaneous pop: write refused on the pre-edge full count
        ready = 1'b0;
        repeat (3) cyc();
        push_words(16, 'h200);
        ready = 1'b1;
        repeat (2) cyc();
        chk("sim_count16", 64'(count), 64'd16);
        in_data  = NB'('h300);
        in_valid = 1'b1;
        #1;
        chk("sim_no_ack", 64'(in_ack), 64'd0);
        cyc();
        chk("sim_count15", 64'(count), 64'd15);
        chk("sim_pop_data", 64'(data), 64'h200);
        chk("sim_ack", 64'(in_ack), 64'd1);
        cyc();
        chk("sim_hold15", 64'(count), 64'd15);
        in_valid = 1'b0;
        edges = 0;
        while (!empty && edges < 40) begin
            cyc();
            edges++;
        end
        chk("sim_drained", 64'(empty), 64'd1);

        // Backpressure: words still arriving after ready drops
        ready = 1'b0;
        repeat (3) cyc();
        push_words(10, 'h400);
        ready = 1'b1;
        repeat (5) cyc();
        ready = 1'b0;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (valid) extra++;
        end
        chk("bp_extra", 64'(extra), 64'd2);
        chk("bp_left", 64'(count), 64'd5);
        push_words(2, 'h500);
        chk("pre_rst_count", 64'(count), 64'd7);

        // Reset mid-operation discards buffered words
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_valid", 64'(valid), 64'd0);
        chk("mid_rst_sent", 64'(sent_count), 64'd0);
        cyc();
        rst_n = 1'b1;
        ready = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (valid) seen = 1'b1;
        end
        chk("post_rst_silent", 64'(seen), 64'd0);
        chk("post_rst_empty", 64'(empty), 64'd1);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
